// File: rtl/bit_packer_if.sv
// Field-in / word-out bus of the bit packer: producer handshake plus FIFO write side.
interface bit_packer_if;
  logic        pushin;
  logic [3:0]  lenin;
  logic [14:0] datain;
  logic        flushin;
  logic        full;
  logic        readyout;
  logic        pushout;
  logic [31:0] dataout;
  logic [5:0]  fillout;

  modport master (
    output pushin, lenin, datain, flushin, full,
    input  readyout, pushout, dataout, fillout
  );

  modport slave (
    input  pushin, lenin, datain, flushin, full,
    output readyout, pushout, dataout, fillout
  );
endinterface

// File: rtl/bit_packer.sv
// Packs variable-length fields (0..15 bits) MSB-first into 32-bit words for a FIFO,
// with a one-word pending buffer that stalls the producer while the FIFO is full.
module bit_packer (
  input  logic         clock,
  input  logic         reset,
  bit_packer_if.slave  bus
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {RUN, HOLD, HOLDF} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   res_p0, res_nxt;
  logic [4:0]          cnt_p0, cnt_nxt;
  logic [DATA_W-1:0]   pw_p0, pw_nxt;
  logic [5:0]          pf_p0, pf_nxt;
  logic                vld_p1, vld_nxt;
  logic [DATA_W-1:0]   word_p1, word_nxt;
  logic [5:0]          fill_p1, fill_nxt;

  logic [3:0]          len_eff;
  logic [15:0]         mask;
  logic [14:0]         field;
  logic [6:0]          shift;
  logic [5:0]          total;
  logic [5:0]          over;
  logic [2*DATA_W-1:0] cat;

  // Residual and new field laid into a 64-bit window; the upper half is the next word.
  assign len_eff = bus.pushin ? bus.lenin : 4'd0;
  assign mask    = (16'd1 << len_eff) - 16'd1;
  assign field   = bus.datain & mask[14:0];
  assign total   = {1'b0, cnt_p0} + {2'b00, len_eff};
  assign over    = total - 6'd32;
  assign shift   = 7'd64 - {2'b00, cnt_p0} - {3'b000, len_eff};
  assign cat     = {res_p0, {DATA_W{1'b0}}} | ({49'd0, field} << shift);

  assign bus.readyout = (state == RUN);
  assign bus.pushout  = vld_p1;
  assign bus.dataout  = word_p1;
  assign bus.fillout  = fill_p1;

  always_comb begin
    state_nxt = state;
    res_nxt   = res_p0;
    cnt_nxt   = cnt_p0;
    pw_nxt    = pw_p0;
    pf_nxt    = pf_p0;
    vld_nxt   = 1'b0;
    word_nxt  = word_p1;
    fill_nxt  = fill_p1;
    case (state)
      RUN: begin
        if (total >= 6'd32) begin
          pw_nxt    = cat[63:32];
          pf_nxt    = 6'd32;
          res_nxt   = cat[31:0];
          cnt_nxt   = over[4:0];
          state_nxt = bus.flushin ? HOLDF : HOLD;
        end else if (bus.flushin && (total != 6'd0)) begin
          pw_nxt    = cat[63:32];
          pf_nxt    = total;
          res_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end else begin
          res_nxt   = cat[63:32];
          cnt_nxt   = total[4:0];
        end
      end
      HOLD: begin
        if (!bus.full) begin
          vld_nxt   = 1'b1;
          word_nxt  = pw_p0;
          fill_nxt  = pf_p0;
          state_nxt = RUN;
        end
      end
      HOLDF: begin
        if (!bus.full) begin
          vld_nxt  = 1'b1;
          word_nxt = pw_p0;
          fill_nxt = pf_p0;
          // The deferred flush turns the overflow remainder into the next pending word.
          if (cnt_p0 != 5'd0) begin
            pw_nxt    = res_p0;
            pf_nxt    = {1'b0, cnt_p0};
            res_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= RUN;
      res_p0  <= '0;
      cnt_p0  <= '0;
      pw_p0   <= '0;
      pf_p0   <= '0;
      vld_p1  <= 1'b0;
      word_p1 <= '0;
      fill_p1 <= '0;
    end else begin
      state   <= state_nxt;
      res_p0  <= res_nxt;
      cnt_p0  <= cnt_nxt;
      pw_p0   <= pw_nxt;
      pf_p0   <= pf_nxt;
      vld_p1  <= vld_nxt;
      word_p1 <= word_nxt;
      fill_p1 <= fill_nxt;
    end
  end
endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: directed scenarios plus a random run scored against a bit-queue model.
module tb_bit_packer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bit_packer_if bus();

  bit_packer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [5:0]  f;
  } word_t;

  int    total = 0;
  int    bad   = 0;
  bit    mon_on = 1'b0;
  bit    bits_q[$];
  word_t exp_q[$];
  int    bits_in  = 0;
  int    bits_out = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: every accepted bit enters a queue; words are cut at 32 bits or on flush.
  task automatic model_accept(input logic p, input logic [3:0] l, input logic [14:0] d, input logic f);
    word_t w;
    if (p) begin
      for (int i = int'(l) - 1; i >= 0; i--) bits_q.push_back(d[i]);
      bits_in += int'(l);
    end
    while (bits_q.size() >= 32) begin
      w.d = '0;
      for (int i = 31; i >= 0; i--) w.d[i] = bits_q.pop_front();
      w.f = 6'd32;
      exp_q.push_back(w);
    end
    if (f && bits_q.size() > 0) begin
      w.d = '0;
      w.f = 6'(bits_q.size());
      for (int i = 31; i >= 0 && bits_q.size() > 0; i--) w.d[i] = bits_q.pop_front();
      exp_q.push_back(w);
    end
  endtask

  task automatic step(input logic p, input logic [3:0] l, input logic [14:0] d,
                      input logic f, input logic fl);
    bus.pushin  = p;
    bus.lenin   = l;
    bus.datain  = d;
    bus.flushin = f;
    bus.full    = fl;
    if (mon_on && bus.readyout) model_accept(p, l, d, f);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic fl);
    step(1'b0, 4'd0, 15'd0, 1'b0, fl);
  endtask

  always @(negedge clock) begin
    if (mon_on && bus.pushout) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_pushout", 32'd1, 32'd0);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        check_val("rand_data", bus.dataout, w.d);
        check_val("rand_fill", {26'd0, bus.fillout}, {26'd0, w.f});
        bits_out += int'(bus.fillout);
      end
    end
  end

  initial begin
    bus.pushin = 1'b0; bus.lenin = '0; bus.datain = '0; bus.flushin = 1'b0; bus.full = 1'b0;

    // Reset state
    reset = 1'b0;
    idle(1'b0);
    idle(1'b0);
    check_val("rst_pushout",  {31'd0, bus.pushout}, 32'd0);
    check_val("rst_dataout",  bus.dataout, 32'h0000_0000);
    check_val("rst_fillout",  {26'd0, bus.fillout}, 32'd0);
    check_val("rst_readyout", {31'd0, bus.readyout}, 32'd1);
    reset = 1'b1;
    idle(1'b0);
    check_val("post_rst_ready", {31'd0, bus.readyout}, 32'd1);

    // Four byte fields make one word
    step(1'b1, 4'd8, 15'h00A1, 1'b0, 1'b0);
    step(1'b1, 4'd8, 15'h00B2, 1'b0, 1'b0);
    step(1'b1, 4'd8, 15'h00C3, 1'b0, 1'b0);
    step(1'b1, 4'd8, 15'h00D4, 1'b0, 1'b0);
    check_val("w4_no_push_yet", {31'd0, bus.pushout}, 32'd0);
    check_val("w4_not_ready",   {31'd0, bus.readyout}, 32'd0);
    idle(1'b0);
    check_val("w4_pushout", {31'd0, bus.pushout}, 32'd1);
    check_val("w4_data",    bus.dataout, 32'hA1B2_C3D4);
    check_val("w4_fill",    {26'd0, bus.fillout}, 32'd32);
    idle(1'b0);
    check_val("w4_one_cycle", {31'd0, bus.pushout}, 32'd0);
    check_val("w4_hold_data", bus.dataout, 32'hA1B2_C3D4);

    // 15-bit fields straddling a word, then flush
    step(1'b1, 4'd15, 15'h7FFF, 1'b0, 1'b0);
    step(1'b1, 4'd15, 15'h0000, 1'b0, 1'b0);
    step(1'b1, 4'd15, 15'h7FFF, 1'b0, 1'b0);
    idle(1'b0);
    check_val("l15_push1", {31'd0, bus.pushout}, 32'd1);
    check_val("l15_data1", bus.dataout, 32'hFFFE_0003);
    check_val("l15_fill1", {26'd0, bus.fillout}, 32'd32);
    step(1'b0, 4'd0, 15'd0, 1'b1, 1'b0);
    idle(1'b0);
    check_val("l15_push2", {31'd0, bus.pushout}, 32'd1);
    check_val("l15_data2", bus.dataout, 32'hFFF8_0000);
    check_val("l15_fill2", {26'd0, bus.fillout}, 32'd13);

    // Backpressure: word pending while full, producer pushes are ignored
    step(1'b1, 4'd8, 15'h0011, 1'b0, 1'b1);
    step(1'b1, 4'd8, 15'h0022, 1'b0, 1'b1);
    step(1'b1, 4'd8, 15'h0033, 1'b0, 1'b1);
    step(1'b1, 4'd8, 15'h0044, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd8, 15'h0055, 1'b0, 1'b1);
      check_val("full_no_push",  {31'd0, bus.pushout}, 32'd0);
      check_val("full_not_ready", {31'd0, bus.readyout}, 32'd0);
    end
    idle(1'b0);
    check_val("full_release_push", {31'd0, bus.pushout}, 32'd1);
    check_val("full_release_data", bus.dataout, 32'h1122_3344);
    idle(1'b0);
    check_val("full_single_push", {31'd0, bus.pushout}, 32'd0);
    step(1'b0, 4'd0, 15'd0, 1'b1, 1'b0);
    check_val("empty_flush_ready", {31'd0, bus.readyout}, 32'd1);
    idle(1'b0);
    check_val("empty_flush_nopush", {31'd0, bus.pushout}, 32'd0);

    // Overflow with simultaneous flush
    step(1'b1, 4'd15, 15'h0000, 1'b0, 1'b0);
    step(1'b1, 4'd15, 15'h0000, 1'b0, 1'b0);
    step(1'b1, 4'd4, 15'h000F, 1'b1, 1'b0);
    idle(1'b0);
    check_val("ovf_push1",  {31'd0, bus.pushout}, 32'd1);
    check_val("ovf_data1",  bus.dataout, 32'h0000_0003);
    check_val("ovf_fill1",  {26'd0, bus.fillout}, 32'd32);
    check_val("ovf_busy",   {31'd0, bus.readyout}, 32'd0);
    idle(1'b0);
    check_val("ovf_push2",  {31'd0, bus.pushout}, 32'd1);
    check_val("ovf_data2",  bus.dataout, 32'hC000_0000);
    check_val("ovf_fill2",  {26'd0, bus.fillout}, 32'd2);
    check_val("ovf_ready",  {31'd0, bus.readyout}, 32'd1);

    // Reset discards a partial word; zero-length push is a no-op
    step(1'b1, 4'd13, 15'h1ABC, 1'b0, 1'b0);
    reset = 1'b0;
    idle(1'b0);
    reset = 1'b1;
    check_val("midrst_dataout", bus.dataout, 32'd0);
    step(1'b0, 4'd0, 15'd0, 1'b1, 1'b0);
    check_val("midrst_flush_ready", {31'd0, bus.readyout}, 32'd1);
    idle(1'b0);
    check_val("midrst_flush_nopush", {31'd0, bus.pushout}, 32'd0);
    step(1'b1, 4'd0, 15'h7FFF, 1'b0, 1'b0);
    check_val("len0_ready", {31'd0, bus.readyout}, 32'd1);
    step(1'b1, 4'd8, 15'h7FAB, 1'b1, 1'b0);
    idle(1'b0);
    check_val("len0_push", {31'd0, bus.pushout}, 32'd1);
    check_val("len0_data", bus.dataout, 32'hAB00_0000);
    check_val("len0_fill", {26'd0, bus.fillout}, 32'd8);
    idle(1'b0);

    // Random traffic against the bit-queue model
    mon_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 15'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 40; i++) begin
      if (bus.readyout && bits_q.size() > 0) step(1'b0, 4'd0, 15'd0, 1'b1, 1'b0);
      else idle(1'b0);
    end
    idle(1'b0);
    mon_on = 1'b0;
    check_val("rand_drained_words", exp_q.size(), 32'd0);
    check_val("rand_drained_bits",  bits_q.size(), 32'd0);
    check_val("rand_bit_count",     bits_out, bits_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
